// File: rtl/demux_deser_2ch.sv
// Two-channel serial-to-parallel deserializer fed by the demux_1x2 bit streams.
// Each lane assembles WIDTH-bit words and hands them off on a valid/ready port.

module demux_deser_lane #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             bit_valid,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             complete;
    logic             load;
    logic             accept;

    // Shift/count update; the completing word is sr_next including the current bit.
    always_comb begin
        sr_next  = sr;
        cnt_next = cnt;
        if (bit_valid) begin
            if (MSB_FIRST) begin
                sr_next = {sr[WIDTH-2:0], din};
            end else begin
                sr_next = {din, sr[WIDTH-1:1]};
            end
            cnt_next = (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign complete = bit_valid && (cnt == LAST);
    assign accept   = word_valid && word_ready;
    // Holding register is usable when empty or being drained on this same edge.
    assign load     = complete && (!word_valid || word_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            sr         <= '0;
            cnt        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            sr   <= sr_next;
            cnt  <= cnt_next;
            busy <= (cnt_next != '0);
            if (load) begin
                word       <= sr_next;
                word_valid <= 1'b1;
            end else if (accept) begin
                word_valid <= 1'b0;
            end
            if (complete && !load) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

module demux_deser_2ch #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_0,
    input  logic             bit_valid_0,
    input  logic             din_1,
    input  logic             bit_valid_1,
    output logic [WIDTH-1:0] word_0,
    output logic             word_valid_0,
    input  logic             word_ready_0,
    output logic [WIDTH-1:0] word_1,
    output logic             word_valid_1,
    input  logic             word_ready_1,
    output logic             overflow_0,
    output logic             overflow_1,
    output logic             busy_0,
    output logic             busy_1
);

    demux_deser_lane #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_lane_0 (
        .clk        (clk),
        .rst        (rst),
        .din        (din_0),
        .bit_valid  (bit_valid_0),
        .word_ready (word_ready_0),
        .word       (word_0),
        .word_valid (word_valid_0),
        .overflow   (overflow_0),
        .busy       (busy_0)
    );

    demux_deser_lane #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_lane_1 (
        .clk        (clk),
        .rst        (rst),
        .din        (din_1),
        .bit_valid  (bit_valid_1),
        .word_ready (word_ready_1),
        .word       (word_1),
        .word_valid (word_valid_1),
        .overflow   (overflow_1),
        .busy       (busy_1)
    );

endmodule

// File: tb/tb_demux_deser_2ch.sv
// Directed bench for demux_deser_2ch: MSB-first instance plus an LSB-first instance.

module tb_demux_deser_2ch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din_0 = 1'b0, bit_valid_0 = 1'b0, word_ready_0 = 1'b0;
    logic       din_1 = 1'b0, bit_valid_1 = 1'b0, word_ready_1 = 1'b0;
    logic [7:0] word_0, word_1;
    logic       word_valid_0, word_valid_1, overflow_0, overflow_1, busy_0, busy_1;

    logic       l_din_1 = 1'b0, l_bit_valid_1 = 1'b0, l_word_ready_1 = 1'b0;
    logic [7:0] l_word_0, l_word_1;
    logic       l_word_valid_0, l_word_valid_1, l_overflow_0, l_overflow_1, l_busy_0, l_busy_1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    demux_deser_2ch #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst),
        .din_0(din_0), .bit_valid_0(bit_valid_0),
        .din_1(din_1), .bit_valid_1(bit_valid_1),
        .word_0(word_0), .word_valid_0(word_valid_0), .word_ready_0(word_ready_0),
        .word_1(word_1), .word_valid_1(word_valid_1), .word_ready_1(word_ready_1),
        .overflow_0(overflow_0), .overflow_1(overflow_1),
        .busy_0(busy_0), .busy_1(busy_1)
    );

    demux_deser_2ch #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst),
        .din_0(1'b0), .bit_valid_0(1'b0),
        .din_1(l_din_1), .bit_valid_1(l_bit_valid_1),
        .word_0(l_word_0), .word_valid_0(l_word_valid_0), .word_ready_0(1'b0),
        .word_1(l_word_1), .word_valid_1(l_word_valid_1), .word_ready_1(l_word_ready_1),
        .overflow_0(l_overflow_0), .overflow_1(l_overflow_1),
        .busy_0(l_busy_0), .busy_1(l_busy_1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] gaps;
        logic [0:7] seq;

        // 1. Reset and basic capture of 0xA5
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_word_0", 32'(word_0), 32'h0);
        check("rst_word_1", 32'(word_1), 32'h0);
        check("rst_valid_0", 32'(word_valid_0), 32'h0);
        check("rst_valid_1", 32'(word_valid_1), 32'h0);
        check("rst_ovf", 32'({overflow_1, overflow_0}), 32'h0);
        check("rst_busy", 32'({busy_1, busy_0}), 32'h0);

        b0 = 8'hA5;
        word_ready_0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din_0 = b0[7-i];
            bit_valid_0 = 1'b1;
            tick();
            check("t1_busy", 32'(busy_0), (i != 7) ? 32'h1 : 32'h0);
            check("t1_valid", 32'(word_valid_0), (i == 7) ? 32'h1 : 32'h0);
        end
        check("t1_word", 32'(word_0), 32'hA5);
        bit_valid_0 = 1'b0;
        tick();
        check("t1_valid_drop", 32'(word_valid_0), 32'h0);
        check("t1_word_hold", 32'(word_0), 32'hA5);

        // 2. Interleaved channels
        b0 = 8'h3C;
        b1 = 8'hC3;
        word_ready_1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if ((i % 2) == 0) begin
                din_0 = b0[7-(i/2)];
                bit_valid_0 = 1'b1;
                din_1 = 1'b0;
                bit_valid_1 = 1'b0;
            end else begin
                din_1 = b1[7-(i/2)];
                bit_valid_1 = 1'b1;
                din_0 = 1'b1;
                bit_valid_0 = 1'b0;
            end
            tick();
            if (i == 14) begin
                check("t2_valid_0", 32'(word_valid_0), 32'h1);
                check("t2_word_0", 32'(word_0), 32'h3C);
                check("t2_valid_1_early", 32'(word_valid_1), 32'h0);
            end
        end
        check("t2_valid_1", 32'(word_valid_1), 32'h1);
        check("t2_word_1", 32'(word_1), 32'hC3);
        check("t2_valid_0_acc", 32'(word_valid_0), 32'h0);
        check("t2_word_0_keep", 32'(word_0), 32'h3C);
        check("t2_ovf", 32'({overflow_1, overflow_0}), 32'h0);
        bit_valid_1 = 1'b0;

        // 3. Backpressure overflow: 0x11 then 0x22 with ready low
        word_ready_0 = 1'b0;
        b0 = 8'h11;
        b1 = 8'h22;
        for (int i = 0; i < 16; i++) begin
            din_0 = (i < 8) ? b0[7-i] : b1[15-i];
            bit_valid_0 = 1'b1;
            tick();
            if (i == 7) begin
                check("t3_first_valid", 32'(word_valid_0), 32'h1);
                check("t3_first_word", 32'(word_0), 32'h11);
            end
            if (i == 14) begin
                check("t3_no_ovf_yet", 32'(overflow_0), 32'h0);
                check("t3_hold_word", 32'(word_0), 32'h11);
            end
        end
        check("t3_ovf", 32'(overflow_0), 32'h1);
        check("t3_word_kept", 32'(word_0), 32'h11);
        check("t3_valid_kept", 32'(word_valid_0), 32'h1);
        check("t3_ovf_1_clear", 32'(overflow_1), 32'h0);
        bit_valid_0 = 1'b0;
        word_ready_0 = 1'b1;
        tick();
        check("t3_valid_drop", 32'(word_valid_0), 32'h0);
        check("t3_ovf_sticky", 32'(overflow_0), 32'h1);

        // 4. Accept on the completion edge
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_ovf_reset", 32'(overflow_0), 32'h0);
        word_ready_0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            din_0 = (i < 8) ? b0[7-i] : b1[15-i];
            bit_valid_0 = 1'b1;
            word_ready_0 = (i == 15);
            tick();
            if (i == 14) begin
                check("t4_pre_valid", 32'(word_valid_0), 32'h1);
                check("t4_pre_word", 32'(word_0), 32'h11);
            end
        end
        check("t4_word", 32'(word_0), 32'h22);
        check("t4_valid", 32'(word_valid_0), 32'h1);
        check("t4_ovf", 32'(overflow_0), 32'h0);
        bit_valid_0 = 1'b0;
        word_ready_0 = 1'b0;
        tick();
        check("t4_stable_valid", 32'(word_valid_0), 32'h1);
        check("t4_stable_word", 32'(word_0), 32'h22);
        word_ready_0 = 1'b1;
        tick();
        check("t4_accept", 32'(word_valid_0), 32'h0);

        // 5. Reset mid-word, then 0xF0 with gaps
        for (int i = 0; i < 4; i++) begin
            din_0 = 1'b1;
            bit_valid_0 = 1'b1;
            tick();
        end
        check("t5_busy_partial", 32'(busy_0), 32'h1);
        bit_valid_0 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy_after_rst", 32'(busy_0), 32'h0);
        b0 = 8'hF0;
        gaps = 8'b0110_1001;
        for (int i = 0; i < 8; i++) begin
            din_0 = b0[7-i];
            bit_valid_0 = 1'b1;
            tick();
            if (gaps[i]) begin
                bit_valid_0 = 1'b0;
                din_0 = ~din_0;
                tick();
                tick();
                check("t5_gap_busy", 32'(busy_0), 32'h1);
                check("t5_gap_valid", 32'(word_valid_0), 32'h0);
            end
        end
        check("t5_word", 32'(word_0), 32'hF0);
        check("t5_valid", 32'(word_valid_0), 32'h1);
        bit_valid_0 = 1'b0;
        tick();
        check("t5_accept", 32'(word_valid_0), 32'h0);

        // rst coincident with the completing bit yields no word
        for (int i = 0; i < 7; i++) begin
            din_0 = 1'b1;
            bit_valid_0 = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bit_valid_0 = 1'b0;
        check("t5_rst_cmp_valid", 32'(word_valid_0), 32'h0);
        check("t5_rst_cmp_word", 32'(word_0), 32'h0);
        check("t5_rst_cmp_busy", 32'(busy_0), 32'h0);
        tick();
        check("t5_rst_cmp_after", 32'(word_valid_0), 32'h0);

        // 6. LSB-first on channel 1 of the second instance
        l_word_ready_1 = 1'b1;
        seq = 8'b1000_0001;
        for (int i = 0; i < 8; i++) begin
            l_din_1 = seq[i];
            l_bit_valid_1 = 1'b1;
            tick();
        end
        check("t6_word_81", 32'(l_word_1), 32'h81);
        check("t6_valid_81", 32'(l_word_valid_1), 32'h1);
        seq = 8'b1100_0000;
        for (int i = 0; i < 8; i++) begin
            l_din_1 = seq[i];
            l_bit_valid_1 = 1'b1;
            tick();
        end
        check("t6_word_03", 32'(l_word_1), 32'h03);
        check("t6_valid_03", 32'(l_word_valid_1), 32'h1);
        check("t6_ovf", 32'(l_overflow_1), 32'h0);
        check("t6_ch0_idle", 32'(l_word_valid_0), 32'h0);
        l_bit_valid_1 = 1'b0;
        tick();
        check("t6_accept", 32'(l_word_valid_1), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
